// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: RS->ALU dispatch and ALU->RS/ROB result bus
interface alu_exec_unit_if #(parameter int XLEN = 32, parameter int ROB_W = 4, parameter int OP_W = 6);
  logic             rs_to_alu_ready;
  logic [OP_W-1:0]  rs_to_alu_op;
  logic [XLEN-1:0]  rs_to_alu_rs1;
  logic [XLEN-1:0]  rs_to_alu_rs2;
  logic [XLEN-1:0]  rs_to_alu_imm;
  logic [XLEN-1:0]  rs_to_alu_PC;
  logic [ROB_W-1:0] rs_to_alu_rob_index;
  logic             alu_to_rs_ready;
  logic [XLEN-1:0]  alu_to_rs_result;
  logic [ROB_W-1:0] alu_to_rs_rob_index;
  logic             alu_to_rob_jump;
  logic [XLEN-1:0]  alu_to_rob_target;
  logic             alu_stall;
  modport master (
    output rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index,
    input  alu_to_rs_ready, alu_to_rs_result, alu_to_rs_rob_index, alu_to_rob_jump, alu_to_rob_target, alu_stall
  );
  modport slave (
    input  rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index,
    output alu_to_rs_ready, alu_to_rs_result, alu_to_rs_rob_index, alu_to_rob_jump, alu_to_rob_target, alu_stall
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle integer/branch ALU; define ALU_MUL_EN for the 3-cycle multiplier
module alu_exec_unit #(parameter int XLEN = 32, parameter int ROB_W = 4, parameter int OP_W = 6) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic clr_in,
  alu_exec_unit_if.slave bus
);
  localparam logic [OP_W-1:0] OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_XOR = 4, OP_SLL = 5,
    OP_SRL = 6, OP_SRA = 7, OP_SLT = 8, OP_SLTU = 9, OP_ADDI = 10, OP_ANDI = 11, OP_ORI = 12,
    OP_XORI = 13, OP_SLLI = 14, OP_SRLI = 15, OP_SRAI = 16, OP_SLTI = 17, OP_SLTIU = 18,
    OP_BEQ = 19, OP_BNE = 20, OP_BLT = 21, OP_BGE = 22, OP_BLTU = 23, OP_BGEU = 24,
    OP_JAL = 25, OP_JALR = 26, OP_LUI = 27, OP_AUIPC = 28,
    OP_MUL = 32, OP_MULH = 33, OP_MULHSU = 34, OP_MULHU = 35;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] a, opb, imm, pc, res_c, tgt_c;
  logic [4:0] sh;
  logic jmp_c, lt, ltu, eq, v, idle, fin, is_mul, accept;
  assign op = bus.rs_to_alu_op;
  assign a = bus.rs_to_alu_rs1;
  assign imm = bus.rs_to_alu_imm;
  assign pc = bus.rs_to_alu_PC;
  assign v = bus.rs_to_alu_ready;
  assign opb = (op inside {[OP_ADDI:OP_SLTIU]}) ? imm : bus.rs_to_alu_rs2;
  assign sh = opb[4:0];
  assign lt = $signed(a) < $signed(opb);
  assign ltu = a < opb;
  assign eq = a == opb;
`ifdef ALU_MUL_EN
  logic sa, sb;
  logic [2*XLEN-1:0] prod;
  // sign-extend to 2*XLEN so one unsigned multiplier covers all four variants
  assign sa = (op == OP_MULH || op == OP_MULHSU) && a[XLEN-1];
  assign sb = op == OP_MULH && opb[XLEN-1];
  assign prod = {{XLEN{sa}}, a} * {{XLEN{sb}}, opb};
`endif
  always_comb begin
    res_c = '0;
    jmp_c = 1'b0;
    tgt_c = pc + imm;
    case (op)
      OP_ADD, OP_ADDI:   res_c = a + opb;
      OP_SUB:            res_c = a - opb;
      OP_AND, OP_ANDI:   res_c = a & opb;
      OP_OR, OP_ORI:     res_c = a | opb;
      OP_XOR, OP_XORI:   res_c = a ^ opb;
      OP_SLL, OP_SLLI:   res_c = a << sh;
      OP_SRL, OP_SRLI:   res_c = a >> sh;
      OP_SRA, OP_SRAI:   res_c = $signed(a) >>> sh;
      OP_SLT, OP_SLTI:   res_c = XLEN'(lt);
      OP_SLTU, OP_SLTIU: res_c = XLEN'(ltu);
      OP_BEQ:            jmp_c = eq;
      OP_BNE:            jmp_c = !eq;
      OP_BLT:            jmp_c = lt;
      OP_BGE:            jmp_c = !lt;
      OP_BLTU:           jmp_c = ltu;
      OP_BGEU:           jmp_c = !ltu;
      OP_JAL:            begin res_c = pc + XLEN'(4); jmp_c = 1'b1; end
      OP_JALR:           begin res_c = pc + XLEN'(4); jmp_c = 1'b1; tgt_c = (a + imm) & ~XLEN'(1); end
      OP_LUI:            res_c = imm;
      OP_AUIPC:          res_c = pc + imm;
`ifdef ALU_MUL_EN
      OP_MUL:            res_c = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_c = prod[2*XLEN-1:XLEN];
`endif
      default:           ;
    endcase
  end
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL1, MUL2} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] mul_res_q;
  logic [ROB_W-1:0] mul_rob_q;
  assign is_mul = op inside {[OP_MUL:OP_MULHU]};
  assign idle = state_q == IDLE;
  assign fin = state_q == MUL2;
  always_ff @(posedge clk_in) state_q <= rst_in ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    state_d = clr_in ? IDLE : !rdy_in ? state_q : idle ? (v && is_mul ? MUL1 : IDLE) : state_q == MUL1 ? MUL2 : IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (rdy_in && idle && v && is_mul) begin
      mul_res_q <= res_c;
      mul_rob_q <= bus.rs_to_alu_rob_index;
    end
  end
`else
  assign is_mul = 1'b0;
  assign idle = 1'b1;
  assign fin = 1'b0;
`endif
  assign accept = idle && v && !is_mul;
  assign bus.alu_stall = !idle;
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      bus.alu_to_rs_ready <= 1'b0;
      bus.alu_to_rs_result <= '0;
      bus.alu_to_rs_rob_index <= '0;
      bus.alu_to_rob_jump <= 1'b0;
      bus.alu_to_rob_target <= '0;
    end else if (rdy_in) begin
      bus.alu_to_rs_ready <= fin || accept;
      bus.alu_to_rob_jump <= accept && jmp_c;
      if (accept) begin
        bus.alu_to_rs_result <= res_c;
        bus.alu_to_rs_rob_index <= bus.rs_to_alu_rob_index;
        bus.alu_to_rob_target <= tgt_c;
      end
`ifdef ALU_MUL_EN
      if (fin) begin
        bus.alu_to_rs_result <= mul_res_q;
        bus.alu_to_rs_rob_index <= mul_rob_q;
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table plus latency/flush/hold sequences for alu_exec_unit
module tb_alu_exec_unit;
  logic clk_in = 1'b0, rst_in, rdy_in, clr_in;
  int total = 0, bad = 0;
  alu_exec_unit_if #(.XLEN(32), .ROB_W(4), .OP_W(6)) bus ();
  alu_exec_unit #(.XLEN(32), .ROB_W(4), .OP_W(6)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic [5:0] op;
    logic [31:0] a, b, imm, pc;
    logic [3:0] rob;
    logic [31:0] res;
    logic jmp;
    logic [31:0] tgt;
  } vec_t;
  vec_t vt[27];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [5:0] op, input logic [31:0] a, b, imm, pc, input logic [3:0] rob);
    bus.rs_to_alu_ready = 1'b1;
    bus.rs_to_alu_op = op;
    bus.rs_to_alu_rs1 = a;
    bus.rs_to_alu_rs2 = b;
    bus.rs_to_alu_imm = imm;
    bus.rs_to_alu_PC = pc;
    bus.rs_to_alu_rob_index = rob;
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic out_chk(input string nm, input logic rdy, input logic [31:0] res, input logic [3:0] rob);
    chk({nm, "_ready"}, 32'(bus.alu_to_rs_ready), 32'(rdy));
    chk({nm, "_result"}, bus.alu_to_rs_result, res);
    chk({nm, "_rob"}, 32'(bus.alu_to_rs_rob_index), 32'(rob));
  endtask
`ifdef ALU_MUL_EN
  task automatic run_mul(input string nm, input logic [5:0] op, input logic [31:0] a, b, input logic [3:0] rob, input logic [31:0] exp);
    issue(op, a, b, 32'h0, 32'h0, rob);
    tick();
    chk({nm, "_stall1"}, 32'(bus.alu_stall), 32'd1);
    chk({nm, "_busy_ready1"}, 32'(bus.alu_to_rs_ready), 32'd0);
    // a dispatch while stalled is illegal and must vanish
    issue(6'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd9);
    tick();
    bus.rs_to_alu_ready = 1'b0;
    chk({nm, "_stall2"}, 32'(bus.alu_stall), 32'd1);
    chk({nm, "_busy_ready2"}, 32'(bus.alu_to_rs_ready), 32'd0);
    tick();
    out_chk(nm, 1'b1, exp, rob);
    chk({nm, "_stall_done"}, 32'(bus.alu_stall), 32'd0);
    tick();
    chk({nm, "_no_extra"}, 32'(bus.alu_to_rs_ready), 32'd0);
  endtask
`endif
  initial begin
    vt[0]  = '{6'd0,  32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 32'd12, 1'b0, 32'd0};
    vt[1]  = '{6'd1,  32'd5, 32'd7, 32'd0, 32'd0, 4'd1, 32'hFFFFFFFE, 1'b0, 32'd0};
    vt[2]  = '{6'd2,  32'hF0F0, 32'hFF00, 32'd0, 32'd0, 4'd2, 32'hF000, 1'b0, 32'd0};
    vt[3]  = '{6'd3,  32'hF0F0, 32'h0F0F, 32'd0, 32'd0, 4'd4, 32'hFFFF, 1'b0, 32'd0};
    vt[4]  = '{6'd4,  32'hFF, 32'h0F, 32'd0, 32'd0, 4'd5, 32'hF0, 1'b0, 32'd0};
    vt[5]  = '{6'd5,  32'd1, 32'h21, 32'd0, 32'd0, 4'd6, 32'd2, 1'b0, 32'd0};
    vt[6]  = '{6'd6,  32'h80000000, 32'd4, 32'd0, 32'd0, 4'd7, 32'h08000000, 1'b0, 32'd0};
    vt[7]  = '{6'd7,  32'h80000000, 32'h24, 32'd0, 32'd0, 4'd8, 32'hF8000000, 1'b0, 32'd0};
    vt[8]  = '{6'd8,  32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 4'd9, 32'd0, 1'b0, 32'd0};
    vt[9]  = '{6'd9,  32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 4'd10, 32'd1, 1'b0, 32'd0};
    vt[10] = '{6'd10, 32'd10, 32'd100, 32'hFFFFFFFD, 32'd0, 4'd11, 32'd7, 1'b0, 32'd0};
    vt[11] = '{6'd16, 32'hFFFFFF00, 32'd0, 32'd4, 32'd0, 4'd12, 32'hFFFFFFF0, 1'b0, 32'd0};
    vt[12] = '{6'd18, 32'd5, 32'd0, 32'd6, 32'd0, 4'd13, 32'd1, 1'b0, 32'd0};
    vt[13] = '{6'd17, 32'hFFFFFFFF, 32'd5, 32'd0, 32'd0, 4'd14, 32'd1, 1'b0, 32'd0};
    vt[14] = '{6'd20, 32'd1, 32'd2, 32'hFFFFFFF8, 32'h100, 4'd15, 32'd0, 1'b1, 32'hF8};
    vt[15] = '{6'd19, 32'd3, 32'd3, 32'h10, 32'h200, 4'd1, 32'd0, 1'b1, 32'h210};
    vt[16] = '{6'd21, 32'hFFFFFFFF, 32'd1, 32'd4, 32'd0, 4'd2, 32'd0, 1'b1, 32'd4};
    vt[17] = '{6'd24, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h10, 4'd3, 32'd0, 1'b1, 32'h20};
    vt[18] = '{6'd23, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h10, 4'd4, 32'd0, 1'b0, 32'd0};
    vt[19] = '{6'd22, 32'd1, 32'd2, 32'h10, 32'h10, 4'd5, 32'd0, 1'b0, 32'd0};
    vt[20] = '{6'd25, 32'd0, 32'd0, 32'h20, 32'h1000, 4'd6, 32'h1004, 1'b1, 32'h1020};
    vt[21] = '{6'd26, 32'h203, 32'd0, 32'd4, 32'h40, 4'd7, 32'h44, 1'b1, 32'h206};
    vt[22] = '{6'd27, 32'd0, 32'd0, 32'h12345000, 32'h40, 4'd8, 32'h12345000, 1'b0, 32'd0};
    vt[23] = '{6'd28, 32'd0, 32'd0, 32'h2000, 32'h100, 4'd9, 32'h2100, 1'b0, 32'd0};
    vt[24] = '{6'd31, 32'd5, 32'd7, 32'd1, 32'h100, 4'd10, 32'd0, 1'b0, 32'd0};
    vt[25] = '{6'd0,  32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 4'd0, 32'd1, 1'b0, 32'd0};
`ifdef ALU_MUL_EN
    vt[26] = '{6'd13, 32'hAAAA, 32'd0, 32'hFFFF, 32'd0, 4'd11, 32'h5555, 1'b0, 32'd0};
`else
    vt[26] = '{6'd32, 32'd7, 32'd6, 32'd0, 32'd0, 4'd11, 32'd0, 1'b0, 32'd0};
`endif
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
    issue(6'd0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd1);
    repeat (3) tick();
    rst_in = 1'b0;
    bus.rs_to_alu_ready = 1'b0;
    out_chk("reset", 1'b0, 32'd0, 4'd0);
    chk("reset_jump", 32'(bus.alu_to_rob_jump), 32'd0);
    chk("reset_target", bus.alu_to_rob_target, 32'd0);
    chk("reset_stall", 32'(bus.alu_stall), 32'd0);
    for (int i = 0; i < 27; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].pc, vt[i].rob);
      tick();
      bus.rs_to_alu_ready = 1'b0;
      out_chk($sformatf("vec%0d", i), 1'b1, vt[i].res, vt[i].rob);
      chk($sformatf("vec%0d_jump", i), 32'(bus.alu_to_rob_jump), 32'(vt[i].jmp));
      chk($sformatf("vec%0d_stall", i), 32'(bus.alu_stall), 32'd0);
      if (vt[i].jmp) chk($sformatf("vec%0d_target", i), bus.alu_to_rob_target, vt[i].tgt);
    end
    tick();
    chk("idle_after_table", 32'(bus.alu_to_rs_ready), 32'd0);
    issue(6'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
    tick();
    out_chk("b2b_add", 1'b1, 32'd2, 4'd1);
    issue(6'd1, 32'd5, 32'd2, 32'd0, 32'd0, 4'd2);
    tick();
    out_chk("b2b_sub", 1'b1, 32'd3, 4'd2);
    issue(6'd4, 32'd6, 32'd3, 32'd0, 32'd0, 4'd3);
    tick();
    bus.rs_to_alu_ready = 1'b0;
    out_chk("b2b_xor", 1'b1, 32'd5, 4'd3);
    tick();
    chk("b2b_idle", 32'(bus.alu_to_rs_ready), 32'd0);
    issue(6'd0, 32'd4, 32'd4, 32'd0, 32'd0, 4'd6);
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    bus.rs_to_alu_ready = 1'b0;
    out_chk("clr_drop", 1'b0, 32'd0, 4'd0);
    issue(6'd0, 32'd2, 32'd3, 32'd0, 32'd0, 4'd7);
    tick();
    rdy_in = 1'b0;
    out_chk("hold_start", 1'b1, 32'd5, 4'd7);
    issue(6'd0, 32'd9, 32'd9, 32'd0, 32'd0, 4'd2);
    tick();
    tick();
    out_chk("hold_persist", 1'b1, 32'd5, 4'd7);
    bus.rs_to_alu_ready = 1'b0;
    rdy_in = 1'b1;
    tick();
    chk("hold_release", 32'(bus.alu_to_rs_ready), 32'd0);
    issue(6'd0, 32'd2, 32'd2, 32'd0, 32'd0, 4'd4);
    tick();
    bus.rs_to_alu_ready = 1'b0;
    rdy_in = 1'b0;
    clr_in = 1'b1;
    tick();
    out_chk("clr_over_rdy", 1'b0, 32'd0, 4'd0);
    rdy_in = 1'b1;
    clr_in = 1'b0;
`ifdef ALU_MUL_EN
    run_mul("mulhu", 6'd35, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 32'hFFFFFFFE);
    run_mul("mul", 6'd32, 32'd7, 32'd6, 4'd6, 32'd42);
    run_mul("mulh", 6'd33, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 32'd0);
    run_mul("mulhsu", 6'd34, 32'hFFFFFFFF, 32'd2, 4'd8, 32'hFFFFFFFF);
    issue(6'd35, 32'd3, 32'd3, 32'd0, 32'd0, 4'd5);
    tick();
    bus.rs_to_alu_ready = 1'b0;
    chk("abort_stall_mul1", 32'(bus.alu_stall), 32'd1);
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    chk("abort_stall_drop", 32'(bus.alu_stall), 32'd0);
    chk("abort_ready0", 32'(bus.alu_to_rs_ready), 32'd0);
    tick();
    chk("abort_ready1", 32'(bus.alu_to_rs_ready), 32'd0);
    tick();
    chk("abort_ready2", 32'(bus.alu_to_rs_ready), 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
